// File: rtl/iq_corr_sequencer.sv
// -----------------------------------------------------------------------------
// iq_corr_sequencer
//
// Sequencer for the IQ demodulator's sample shift register. Decimates the
// incoming sample stream, pushes one sample into the external shift register
// per decimation event, then walks the taps one per cycle through a single
// shared add/subtract accumulator to form a +/-1 weighted chip correlation.
// The result is offered to the chip decision logic on a valid/ready pair.
//
// Ports:
//   clk          main clock, single domain
//   reset        synchronous reset, active-high, priority over everything
//   sample_in    signed 5-bit input sample
//   sample_valid sample_in valid this cycle
//   shift_en     one-cycle shift strobe to the shift register
//   shift_data   registered sample to shift in (valid with shift_en)
//   tap_sel      tap index driven to the shift register output mux
//   tap_data     signed tap value selected by tap_sel (same-cycle mux)
//   corr_out     signed correlation result
//   corr_valid   corr_out valid
//   out_ready    downstream accepts corr_out
//   overrun      sticky flag: a decimation event arrived while busy
// -----------------------------------------------------------------------------
module iq_corr_sequencer #(
    parameter int               NTAPS = 10,
    parameter int               DECIM = 5,
    parameter logic [NTAPS-1:0] COEF  = 10'b1011001110
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [4:0] sample_in,
    input  logic              sample_valid,
    output logic              shift_en,
    output logic signed [4:0] shift_data,
    output logic        [3:0] tap_sel,
    input  logic signed [4:0] tap_data,
    output logic signed [8:0] corr_out,
    output logic              corr_valid,
    input  logic              out_ready,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACCUM,
        OUT
    } state_t;

    localparam logic [3:0]  DCNT_LAST = 4'(DECIM - 1);
    localparam logic [3:0]  TAP_LAST  = 4'(NTAPS - 1);
    // Widened copy so the 4-bit tap index can address it for any NTAPS.
    localparam logic [15:0] COEF_EXT  = 16'(COEF);

    state_t            state;
    logic        [3:0] dcnt;
    logic signed [8:0] acc;
    logic              dec_event;
    logic signed [8:0] tap_ext;
    logic signed [8:0] acc_next;

    assign dec_event = sample_valid && (dcnt == DCNT_LAST);

    // NOTE: every signal in this block is assigned on every path, so it
    // stays purely combinational (no latch).
    always_comb begin
        tap_ext  = {{4{tap_data[4]}}, tap_data};
        acc_next = COEF_EXT[tap_sel] ? (acc + tap_ext) : (acc - tap_ext);
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dcnt       <= '0;
            acc        <= '0;
            shift_en   <= 1'b0;
            shift_data <= '0;
            tap_sel    <= '0;
            corr_out   <= '0;
            corr_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // The decimation counter free-runs on strobes regardless of
            // whether the resulting event is accepted.
            if (sample_valid) begin
                dcnt <= dec_event ? 4'd0 : dcnt + 4'd1;
            end

            shift_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (dec_event) begin
                        shift_data <= sample_in;
                        shift_en   <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc     <= '0;
                    tap_sel <= '0;
                    state   <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc_next;
                    if (tap_sel == TAP_LAST) begin
                        tap_sel    <= '0;
                        corr_out   <= acc_next;
                        corr_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        tap_sel <= tap_sel + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        corr_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase

            // Any event outside IDLE is lost, including the handshake
            // cycle of OUT.
            if (dec_event && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
